// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames 5-byte command packets (sync, id, data_hi, data_lo, chk)
// from the uart_rx byte stream, checks the XOR checksum and an inter-byte timeout,
// and presents one validated command per packet as a single-cycle strobe.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic        i_Clock,
  input  logic        i_Rst,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Id,
  output logic [15:0] o_Cmd_Data,
  output logic        o_Cmd_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Busy
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CLKS);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] ErrChecksum = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StGetId,
    StGetHi,
    StGetLo,
    StGetChk
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      id_q, id_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      lo_q, lo_d;

  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_id_q, cmd_id_d;
  logic [15:0]     cmd_data_q, cmd_data_d;
  logic            cmd_err_q, cmd_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;

  logic            timeout;
  logic            chk_ok;

  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  assign timeout = (state_q != StIdle) && !i_Rx_DV && (cnt_q == CntLast);
  assign chk_ok  = (i_Rx_Byte == (id_q ^ hi_q ^ lo_q));

  // State, counter, shadow and output registers.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      id_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      cmd_data_q  <= '0;
      cmd_err_q   <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      cmd_data_q  <= cmd_data_d;
      cmd_err_q   <= cmd_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: advance one state per accepted byte, abort to idle on timeout.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StIdle;
    end else if (i_Rx_DV) begin
      unique case (state_q)
        StIdle:   if (i_Rx_Byte == SYNC_BYTE) state_d = StGetId;
        StGetId:  state_d = StGetHi;
        StGetHi:  state_d = StGetLo;
        StGetLo:  state_d = StGetChk;
        StGetChk: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Next values for counter, shadows and registered outputs.
  always_comb begin
    cnt_d       = cnt_q;
    id_d        = id_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cmd_valid_d = 1'b0;
    cmd_id_d    = cmd_id_q;
    cmd_data_d  = cmd_data_q;
    cmd_err_d   = 1'b0;
    err_code_d  = err_code_q;
    busy_d      = (state_d != StIdle);

    if (state_q == StIdle || i_Rx_DV) begin
      cnt_d = '0;
    end else if (timeout) begin
      cnt_d      = '0;
      id_d       = '0;
      hi_d       = '0;
      lo_d       = '0;
      cmd_err_d  = 1'b1;
      err_code_d = ErrTimeout;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (i_Rx_DV) begin
      unique case (state_q)
        StGetId: id_d = i_Rx_Byte;
        StGetHi: hi_d = i_Rx_Byte;
        StGetLo: lo_d = i_Rx_Byte;
        StGetChk: begin
          if (chk_ok) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = id_q;
            cmd_data_d  = {hi_q, lo_q};
          end else begin
            cmd_err_d   = 1'b1;
            err_code_d  = ErrChecksum;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Cmd_Valid = cmd_valid_q;
  assign o_Cmd_Id    = cmd_id_q;
  assign o_Cmd_Data  = cmd_data_q;
  assign o_Cmd_Err   = cmd_err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed byte streams; expected strobes are queued
// by the stimulus and matched by an independent monitor on the falling edge.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  rx_byte;
  logic        cmd_valid;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_data;
  logic        cmd_err;
  logic [1:0]  err_code;
  logic        busy;

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hAA),
    .TIMEOUT_CLKS(16)
  ) dut (
    .i_Clock    (clk),
    .i_Rst      (rst),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (rx_byte),
    .o_Cmd_Valid(cmd_valid),
    .o_Cmd_Id   (cmd_id),
    .o_Cmd_Data (cmd_data),
    .o_Cmd_Err  (cmd_err),
    .o_Err_Code (err_code),
    .o_Busy     (busy)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic expect_valid(input logic [7:0] id, input logic [15:0] data, input int at);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.id = id; e.data = data; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [1:0] code, input logic [7:0] id,
                            input logic [15:0] data, input int at);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.id = id; e.data = data; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Call at a falling edge; the byte is sampled at the next rising edge (edge_n).
  task automatic send(input logic [7:0] b, input int gap, output int edge_n);
    dv      = 1'b1;
    rx_byte = b;
    edge_n  = cyc + 1;
    @(negedge clk);
    dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (cmd_valid || cmd_err)) begin
      check("valid_err_exclusive", {31'b0, cmd_valid & cmd_err}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b, expected none (cyc %0d)",
                 cmd_valid, cmd_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind_err", {31'b0, cmd_err}, {31'b0, mon_e.is_err});
        check("strobe_cycle", cyc, mon_e.cyc);
        check("cmd_id", {24'b0, cmd_id}, {24'b0, mon_e.id});
        check("cmd_data", {16'b0, cmd_data}, {16'b0, mon_e.data});
        if (mon_e.is_err) check("err_code", {30'b0, err_code}, {30'b0, mon_e.code});
      end
    end
  end

  int e;

  initial begin
    rst     = 1'b1;
    dv      = 1'b0;
    rx_byte = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_valid_err_busy", {29'b0, cmd_valid, cmd_err, busy}, 32'd0);
    check("reset_id", {24'b0, cmd_id}, 32'd0);
    check("reset_data", {16'b0, cmd_data}, 32'd0);
    check("reset_code", {30'b0, err_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Valid packet, bytes 5 idle cycles apart.
    send(8'hAA, 5, e);
    check("busy_after_sync", {31'b0, busy}, 32'd1);
    send(8'h12, 5, e);
    send(8'h34, 5, e);
    send(8'h56, 5, e);
    expect_valid(8'h12, 16'h3456, cyc + 1);
    send(8'h70, 5, e);
    check("busy_after_valid", {31'b0, busy}, 32'd0);

    // Bad checksum: command fields keep their previous values.
    send(8'hAA, 5, e);
    send(8'h12, 5, e);
    send(8'h34, 5, e);
    send(8'h56, 5, e);
    expect_err(2'b01, 8'h12, 16'h3456, cyc + 1);
    send(8'h71, 5, e);
    check("busy_after_chk_err", {31'b0, busy}, 32'd0);

    // Timeout: error 16 edges after the last accepted byte.
    send(8'hAA, 2, e);
    expect_err(2'b10, 8'h12, 16'h3456, cyc + 1 + 16);
    send(8'h12, 20, e);
    check("busy_after_timeout", {31'b0, busy}, 32'd0);
    send(8'hAA, 2, e);
    send(8'h01, 2, e);
    send(8'h00, 2, e);
    send(8'h02, 2, e);
    expect_valid(8'h01, 16'h0002, cyc + 1);
    send(8'h03, 3, e);
    check("err_code_held", {30'b0, err_code}, 32'd2);

    // Timeout boundary: each body byte lands exactly on the terminal-count cycle.
    send(8'hAA, 15, e);
    send(8'h12, 15, e);
    send(8'h34, 15, e);
    send(8'h56, 15, e);
    expect_valid(8'h12, 16'h3456, cyc + 1);
    send(8'h70, 5, e);

    // Leading garbage ignored; sync value inside the body is plain data.
    send(8'h00, 2, e);
    send(8'hFF, 2, e);
    check("busy_after_garbage", {31'b0, busy}, 32'd0);
    send(8'hAA, 1, e);
    send(8'hAA, 1, e);
    send(8'hAA, 1, e);
    send(8'hAA, 1, e);
    expect_valid(8'hAA, 16'hAAAA, cyc + 1);
    send(8'hAA, 3, e);

    // Asynchronous reset mid-packet clears everything immediately.
    send(8'hAA, 1, e);
    send(8'h12, 1, e);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid_err_busy", {29'b0, cmd_valid, cmd_err, busy}, 32'd0);
    check("midrst_id", {24'b0, cmd_id}, 32'd0);
    check("midrst_data", {16'b0, cmd_data}, 32'd0);
    check("midrst_code", {30'b0, err_code}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back packets on consecutive cycles.
    send(8'hAA, 0, e);
    send(8'h01, 0, e);
    send(8'h00, 0, e);
    send(8'h02, 0, e);
    expect_valid(8'h01, 16'h0002, cyc + 1);
    send(8'h03, 0, e);
    send(8'hAA, 0, e);
    send(8'h05, 0, e);
    send(8'h12, 0, e);
    send(8'h34, 0, e);
    expect_valid(8'h05, 16'h1234, cyc + 1);
    send(8'h23, 3, e);
    check("busy_after_b2b", {31'b0, busy}, 32'd0);

    repeat (20) @(negedge clk);
    check("all_expected_seen", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Packet-level receive controller sitting directly behind `uart_rx`. It consumes the byte stream (`o_Rx_DV` / `o_Rx_Byte`) and frames fixed 5-byte command packets (sync, ID, data high, data low, checksum). It enforces an inter-byte timeout and XOR checksum, then hands one validated command per packet to the motor/sensor control logic as a single-cycle strobe.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hAA: packet start marker.
- `TIMEOUT_CLKS`, 100000: maximum clocks allowed between accepted bytes inside a packet; must be ≥ 2. The counter width is `$clog2(TIMEOUT_CLKS)`.

Ports:
- `i_Clock`, in, 1: single clock, shared with `uart_rx`.
- `i_Rst`, in, 1: reset, asynchronous and active-high.
- `i_Rx_DV`, in, 1: byte-valid strobe from `uart_rx`, one cycle per byte.
- `i_Rx_Byte`, in, 8: received byte, valid when `i_Rx_DV`=1.
- `o_Cmd_Valid`, out, 1: one-cycle pulse when a packet passes the checksum.
- `o_Cmd_Id`, out, 8: command ID of the last valid packet; held between packets.
- `o_Cmd_Data`, out, 16: {data_hi, data_lo} of the last valid packet; held between packets.
- `o_Cmd_Err`, out, 1: one-cycle pulse on a checksum failure or a timeout.
- `o_Err_Code`, out, 2: cause of the error; 2'b01 = checksum, 2'b10 = timeout. Held until the next error.
- `o_Busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, GET_ID, GET_HI, GET_LO, GET_CHK. All state and outputs are registered.
- IDLE:
  - A byte equal to `SYNC_BYTE` moves the state to GET_ID.
  - Any other byte is silently discarded; no error is raised.
- GET_ID, GET_HI and GET_LO each latch the byte into a shadow register and advance to the next state.
- A `SYNC_BYTE` value received inside the packet body is treated as data; there is no resynchronisation.
- GET_CHK computes chk = id ^ hi ^ lo.
  - Match: `o_Cmd_Id`/`o_Cmd_Data` load from the shadow registers, `o_Cmd_Valid` pulses, and the state returns to IDLE.
  - Mismatch: `o_Cmd_Err` pulses, `o_Err_Code`=01, command outputs are unchanged, and the state returns to IDLE.
- Timeout counter behaviour:
  - Cleared on every accepted byte.
  - Increments on each cycle without `i_Rx_DV` while in a non-IDLE state.
  - Held at 0 in IDLE.
- When the counter equals `TIMEOUT_CLKS-1` and `i_Rx_DV`=0:
  - `o_Cmd_Err` pulses and `o_Err_Code`=10.
  - The shadow registers are discarded and the state returns to IDLE.
- Simultaneous `i_Rx_DV` and timeout terminal count: the byte wins and no timeout fires.
- Reset, including mid-packet: state goes to IDLE, counter and shadows clear, and all outputs go to 0 (`o_Cmd_Id`=0, `o_Cmd_Data`=0, `o_Err_Code`=00, strobes low, `o_Busy`=0).

## Timing
- Latency: `o_Cmd_Valid` or checksum `o_Cmd_Err` is high in the cycle immediately after the cycle in which `i_Rx_DV` carried the checksum byte. `o_Cmd_Id`/`o_Cmd_Data` are updated on that same edge.
- Timeout latency: with the last byte accepted at edge n, `o_Cmd_Err` is high in the cycle following edge n+`TIMEOUT_CLKS`.
- `o_Busy` rises in the cycle after the sync byte's DV and falls in the same cycle as the final `o_Cmd_Valid`/`o_Cmd_Err` pulse.
- Back-to-back packets: a sync byte with DV in the cycle directly after `o_Cmd_Valid` must be accepted. `uart_rx` cannot deliver bytes faster than one per 10 bit-times, but the parser must accept DV on any cycle, including consecutive cycles.
- `o_Cmd_Valid` and `o_Cmd_Err` are never high in the same cycle.
- No flow control back to `uart_rx`; bytes are never stalled.

## Test plan
- **Valid packet.** Reset, then bytes AA,12,34,56,70 with DV 1 cycle each, 5 idle cycles apart.
  - `o_Cmd_Valid` pulses once, one cycle after the 70 DV.
  - `o_Cmd_Id`=12, `o_Cmd_Data`=3456, `o_Cmd_Err`=0, `o_Busy` low afterwards.
- **Bad checksum.** Bytes AA,12,34,56,71.
  - `o_Cmd_Err` pulses with `o_Err_Code`=01.
  - `o_Cmd_Valid` never asserts; `o_Cmd_Id`/`o_Cmd_Data` keep their prior values.
- **Timeout.** `TIMEOUT_CLKS`=16; send AA,12, then no DV.
  - `o_Cmd_Err` pulses 16 edges after the 12 DV, with `o_Err_Code`=10.
  - A following AA,01,00,02,03 yields `o_Cmd_Valid` with Id=01, Data=0002.
- **Timeout boundary.** `TIMEOUT_CLKS`=16; send the next byte with DV exactly on the terminal-count cycle.
  - No error; the packet completes normally.
- **Garbage and embedded sync.** Send 00,FF,AA,AA,AA,AA,AA.
  - Leading 00,FF are ignored.
  - The packet is Id=AA, hi=AA, lo=AA, chk=AA (AA^AA^AA=AA), so it is valid: `o_Cmd_Valid`, Id=AA, Data=AAAA.
- **Reset mid-packet, then back-to-back.** Assert `i_Rst` asynchronously after AA,12.
  - All outputs are 0 immediately.
  - Two consecutive valid packets, with the second sync DV in the cycle after the first `o_Cmd_Valid`, produce two `o_Cmd_Valid` pulses with correct fields.
